// File: rtl/spi_txn_arbiter_if.sv
// Requester/master-side bundle of the SPI transaction arbiter.
// The arbiter connects through 'slave'; the requesters and SPI master model sit on 'master'.
interface spi_txn_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_wr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            done;
   logic                          err;
   logic                          busy;
   logic                          m_newtxn;
   logic                          m_wren;
   logic [DATA_WIDTH-1:0]         m_data;
   logic                          m_cs;

   modport slave (
      input  req, req_wr, req_data, m_cs,
      output gnt, done, err, busy, m_newtxn, m_wren, m_data
   );

   modport master (
      output req, req_wr, req_data, m_cs,
      input  gnt, done, err, busy, m_newtxn, m_wren, m_data
   );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters, with
// cs-based transaction tracking, an idle gap between transactions and a hang timeout.
module spi_txn_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   spi_txn_arbiter_if.slave    bus
);

   localparam int unsigned IDX_W    = $clog2(NUM_REQ);
   localparam int unsigned CNT_MAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t                 r_state,  w_state_nxt;
   logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
   logic [IDX_W-1:0]       r_rr_ptr, w_rr_nxt;
   logic [NUM_REQ-1:0]     r_gnt,    w_gnt_nxt;
   logic [NUM_REQ-1:0]     r_done,   w_done_nxt;
   logic                   r_err,    w_err_nxt;
   logic                   r_busy,   w_busy_nxt;
   logic                   r_newtxn, w_newtxn_nxt;
   logic                   r_wren,   w_wren_nxt;
   logic [DATA_WIDTH-1:0]  r_data,   w_data_nxt;

   logic                   w_found;
   logic [IDX_W-1:0]       w_win;
   logic [NUM_REQ-1:0]     w_owner;
   logic [DATA_WIDTH-1:0]  w_win_data;
   logic                   w_timeout;

   // First requester at or after rr_ptr+1, wrapping at NUM_REQ.
   always_comb begin : arb_pick
      logic [IDX_W-1:0] v_sel;
      w_found = 1'b0;
      w_win   = '0;
      v_sel   = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         v_sel = IDX_W'((32'(r_rr_ptr) + off) % NUM_REQ);
         if (!w_found && bus.req[v_sel]) begin
            w_found = 1'b1;
            w_win   = v_sel;
         end
      end
   end

   assign w_win_data = DATA_WIDTH'(bus.req_data >> (32'(w_win) * DATA_WIDTH));
   assign w_owner    = NUM_REQ'(1) << r_rr_ptr;
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rr_nxt     = r_rr_ptr;
      w_gnt_nxt    = '0;
      w_done_nxt   = '0;
      w_err_nxt    = 1'b0;
      w_newtxn_nxt = r_newtxn;
      w_wren_nxt   = r_wren;
      w_data_nxt   = r_data;

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt  = S_LAUNCH;
               w_gnt_nxt    = NUM_REQ'(1) << w_win;
               w_wren_nxt   = bus.req_wr[w_win];
               w_data_nxt   = w_win_data;
               w_rr_nxt     = w_win;
               w_newtxn_nxt = 1'b1;
               w_cnt_nxt    = '0;
            end
         end
         S_LAUNCH: begin
            w_newtxn_nxt = 1'b1;
            // cs falling on the timeout cycle still counts as a start.
            if (!bus.m_cs) begin
               w_state_nxt  = S_BUSY;
               w_newtxn_nxt = 1'b0;
               w_cnt_nxt    = '0;
            end else if (w_timeout) begin
               w_state_nxt  = S_GAP;
               w_newtxn_nxt = 1'b0;
               w_done_nxt   = w_owner;
               w_err_nxt    = 1'b1;
               w_cnt_nxt    = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_BUSY: begin
            w_newtxn_nxt = 1'b0;
            if (bus.m_cs) begin
               w_state_nxt = S_GAP;
               w_done_nxt  = w_owner;
               w_cnt_nxt   = '0;
            end else if (w_timeout) begin
               w_state_nxt = S_GAP;
               w_done_nxt  = w_owner;
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(GAP_LAST)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_newtxn_nxt = 1'b0;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rr_ptr <= IDX_W'(NUM_REQ - 1);
         r_gnt    <= '0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_newtxn <= 1'b0;
         r_wren   <= 1'b0;
         r_data   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_gnt    <= w_gnt_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_busy   <= w_busy_nxt;
         r_newtxn <= w_newtxn_nxt;
         r_wren   <= w_wren_nxt;
         r_data   <= w_data_nxt;
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.busy     = r_busy;
   assign bus.m_newtxn = r_newtxn;
   assign bus.m_wren   = r_wren;
   assign bus.m_data   = r_data;

endmodule
